// File: rtl/scan_mux_pipe_if.sv
// Channel bus for scan_mux_pipe: the multi-channel sample input with its select
// controls, and the registered single-channel output with its channel tag.
interface scan_mux_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      en;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          y_ch;
  logic                      y_valid;

  modport master (output in, sel, mode, en, input y, y_ch, y_valid);
  modport slave  (input in, sel, mode, en, output y, y_ch, y_valid);
endinterface

// File: rtl/scan_mux_pipe.sv
// Pipelined N:1 mux built as a registered binary tree of 2:1 stages, with a
// manual select mode and a round-robin scan mode that dwells DWELL samples per channel.
module scan_mux_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input logic           clk,
  input logic           rst,
  scan_mux_pipe_if.slave bus
);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SEL_W-1:0] scan_ch;
  logic [DW_W-1:0]  dwell_cnt;
  logic [SEL_W-1:0] eff_sel;

  logic [WIDTH-1:0] leaf [CHANNELS];
  // Registered tree nodes, level k (k>=1) stored from lvl_base(k) onward; the root is last.
  logic [WIDTH-1:0] node [CHANNELS-1];
  logic [SEL_W-1:0] ch_q [1:SEL_W];
  logic [SEL_W:1]   v_q;

  function automatic int lvl_base(input int k);
    return CHANNELS - 2 * (CHANNELS >> k);
  endfunction

  assign eff_sel = bus.mode ? scan_ch : bus.sel;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      leaf[c] = bus.in[c*WIDTH +: WIDTH];
    end
  end

  // Scan position advances only on accepted samples, after the current one has used it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ch   <= '0;
      dwell_cnt <= '0;
    end else if (!bus.mode) begin
      scan_ch   <= '0;
      dwell_cnt <= '0;
    end else if (bus.en) begin
      if (dwell_cnt == DW_W'(DWELL - 1)) begin
        dwell_cnt <= '0;
        scan_ch   <= scan_ch + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  // Each level consumes the select bit matching its depth from the index captured with the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS - 1; i++) begin
        node[i] <= '0;
      end
      for (int k = 1; k <= SEL_W; k++) begin
        ch_q[k] <= '0;
      end
      v_q <= '0;
    end else begin
      for (int j = 0; j < CHANNELS / 2; j++) begin
        node[j] <= leaf[2*j + int'(eff_sel[0])];
      end
      ch_q[1] <= eff_sel;
      v_q[1]  <= bus.en;
      for (int k = 2; k <= SEL_W; k++) begin
        for (int j = 0; j < (CHANNELS >> k); j++) begin
          node[lvl_base(k) + j] <= node[lvl_base(k-1) + 2*j + int'(ch_q[k-1][k-1])];
        end
        ch_q[k] <= ch_q[k-1];
        v_q[k]  <= v_q[k-1];
      end
    end
  end

  assign bus.y       = node[CHANNELS-2];
  assign bus.y_ch    = ch_q[SEL_W];
  assign bus.y_valid = v_q[SEL_W];
endmodule
